// File: rtl/house_status_tx.sv
// Status telemetry transmitter: snapshots synchronised house status and sends a
// 4-byte UART 8N1 frame (A5, STAT_A, STAT_B, CHK) on change or periodically.
module house_status_tx #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int REPORT_MS = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       smoke,
    input  logic       buzzer,
    input  logic       led_alert,
    input  logic [1:0] switch_pos,
    input  logic       limit_up_n,
    input  logic       limit_down_n,
    input  logic       presence_1,
    input  logic       presence_2,
    input  logic       light_1,
    input  logic       light_2,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] seq
);

    localparam int CLKS_PER_BIT  = CLK_HZ / BAUD;
    localparam int REPORT_CYCLES = (CLK_HZ / 1000) * REPORT_MS;
    localparam int BIT_W         = $clog2(CLKS_PER_BIT);
    localparam int RPT_W         = $clog2(REPORT_CYCLES);

    localparam logic [7:0]       SYNC_BYTE = 8'hA5;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPORT_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_ARM   = RPT_W'(REPORT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [10:0]        raw_status, sync_p0, sync_p1, snap;
    logic [BIT_W-1:0]   bit_tmr;
    logic [2:0]         bit_cnt;
    logic [1:0]         byte_idx;
    logic [RPT_W-1:0]   rpt_tmr;
    logic               pending;
    logic [7:0]         stat_a_q, stat_b_q, chk_q, cur_byte;
    logic [7:0]         stat_a_next, stat_b_next;
    logic [3:0]         seq_launch;
    logic               bit_end, last_byte, frame_end, launch;

    // Limit switches are inverted up front so an all-inactive house reads as zero.
    assign raw_status = {smoke, buzzer, led_alert, ~limit_up_n, ~limit_down_n, switch_pos,
                         light_2, light_1, presence_2, presence_1};

    // Stage p0/p1: two-flop synchronisers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw_status;
            sync_p1 <= sync_p0;
        end
    end

    assign bit_end   = (bit_tmr == BIT_LAST);
    assign last_byte = (byte_idx == 2'd3);
    assign frame_end = (state == STOP) && bit_end && last_byte;
    // A pending frame launches from IDLE, or straight out of the last stop bit so
    // back-to-back frames have no idle cycle between them.
    assign launch    = pending && ((state == IDLE) || frame_end);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (pending) state_next = START;
            START: if (bit_end) state_next = DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (bit_end) state_next = (!last_byte || pending) ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_tmr  <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            seq      <= '0;
        end else begin
            if (state == IDLE) begin
                bit_tmr  <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
            end else begin
                bit_tmr <= bit_end ? '0 : bit_tmr + BIT_W'(1);
                if (state == DATA && bit_end) bit_cnt  <= bit_cnt + 3'd1;
                if (state == STOP && bit_end) byte_idx <= byte_idx + 2'd1;
            end
            if (frame_end) seq <= seq + 4'd1;
        end
    end

    // A frame launched on the final stop cycle must already carry the incremented seq.
    assign seq_launch  = frame_end ? seq + 4'd1 : seq;
    assign stat_a_next = {1'b0, sync_p1[10:4]};
    assign stat_b_next = {seq_launch, sync_p1[3:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap     <= '0;
            stat_a_q <= '0;
            stat_b_q <= '0;
            chk_q    <= '0;
        end else if (launch) begin
            snap     <= sync_p1;
            stat_a_q <= stat_a_next;
            stat_b_q <= stat_b_next;
            chk_q    <= SYNC_BYTE ^ stat_a_next ^ stat_b_next;
        end
    end

    // Pending is armed one cycle early so it is visible when the timer hits its last count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b1;
            rpt_tmr <= '0;
        end else if (launch) begin
            pending <= 1'b0;
            rpt_tmr <= '0;
        end else begin
            if (rpt_tmr != RPT_LAST) rpt_tmr <= rpt_tmr + RPT_W'(1);
            if ((sync_p1 != snap) || (rpt_tmr == RPT_ARM)) pending <= 1'b1;
        end
    end

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            2'd1:    cur_byte = stat_a_q;
            2'd2:    cur_byte = stat_b_q;
            2'd3:    cur_byte = chk_q;
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_cnt];
            default: tx = 1'b1;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = frame_end;

endmodule
